// File: rtl/fifo_pop_pkg.sv
// Shared types and constants for the FIFO pop stream stage and its sequence checker.
package fifo_pop_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_EMPTY = 2'd0;
    localparam state_t ST_ONE   = 2'd1;
    localparam state_t ST_FULL  = 2'd2;

    localparam int unsigned     ERR_CNT_W   = 16;
    localparam logic [15:0]     ERR_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/fifo_pop_seq_check.sv
// Incrementing-sequence checker: compares each accepted word against a free-running
// expected value and keeps a saturating mismatch count plus a sticky flag.
module fifo_pop_seq_check
    import fifo_pop_pkg::*;
#(
    parameter int unsigned            DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]  SEQ_INIT   = '0
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  take,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [ERR_CNT_W-1:0]  ERR_CNT,
    output logic                  ERR_FLAG
);

    logic [DATA_WIDTH-1:0] expected_q, expected_d;
    logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic                  err_flag_q, err_flag_d;
    logic                  mismatch_c;

    assign mismatch_c = take && (data != expected_q);

    // Expected value advances on every take and is never resynchronised to the data.
    always_comb begin
        expected_d = expected_q;
        err_cnt_d  = err_cnt_q;
        err_flag_d = err_flag_q;
        if (take) begin
            expected_d = expected_q + DATA_WIDTH'(1);
        end
        if (mismatch_c) begin
            err_flag_d = 1'b1;
            if (err_cnt_q != ERR_CNT_MAX) begin
                err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            expected_q <= SEQ_INIT;
            err_cnt_q  <= '0;
            err_flag_q <= 1'b0;
        end else begin
            expected_q <= expected_d;
            err_cnt_q  <= err_cnt_d;
            err_flag_q <= err_flag_d;
        end
    end

    assign ERR_CNT  = err_cnt_q;
    assign ERR_FLAG = err_flag_q;

endmodule

// File: rtl/fifo_pop_stream.sv
// Read-side consumer for a first-word-fall-through FIFO: pops into a 2-entry skid buffer
// and presents a valid/ready stream. Optional checker enabled by FIFO_POP_SEQ_CHECK_EN.
module fifo_pop_stream
    import fifo_pop_pkg::*;
#(
    parameter int unsigned            DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]  SEQ_INIT   = '0
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  F_EMPTY,
    input  logic [DATA_WIDTH-1:0] F_DATA,
    output logic                  F_nEN,
    output logic                  O_VALID,
    input  logic                  O_READY,
    output logic [DATA_WIDTH-1:0] O_DATA,
    output logic [31:0]           XFER_CNT,
    output logic [ERR_CNT_W-1:0]  ERR_CNT,
    output logic                  ERR_FLAG
);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic [31:0]           xfer_cnt_q, xfer_cnt_d;
    logic                  push_c;
    logic                  take_c;

    // Pop decision never depends on O_READY, so the FIFO side has no ready-to-enable path.
    assign push_c  = !F_EMPTY && (state_q != ST_FULL) && nRST;
    assign take_c  = O_VALID && O_READY;
    assign F_nEN   = !push_c;
    assign O_VALID = (state_q != ST_EMPTY);

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        skid_d     = skid_q;
        xfer_cnt_d = xfer_cnt_q;
        if (take_c) begin
            xfer_cnt_d = xfer_cnt_q + 32'(1);
        end
        case (state_q)
            ST_EMPTY: begin
                if (push_c) begin
                    state_d = ST_ONE;
                    head_d  = F_DATA;
                end
            end
            ST_ONE: begin
                if (push_c && !take_c) begin
                    state_d = ST_FULL;
                    skid_d  = F_DATA;
                end else if (push_c && take_c) begin
                    head_d  = F_DATA;
                end else if (take_c) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (take_c) begin
                    state_d = ST_ONE;
                    head_d  = skid_q;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q    <= ST_EMPTY;
            head_q     <= '0;
            skid_q     <= '0;
            xfer_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            skid_q     <= skid_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign O_DATA   = head_q;
    assign XFER_CNT = xfer_cnt_q;

`ifdef FIFO_POP_SEQ_CHECK_EN
    fifo_pop_seq_check #(
        .DATA_WIDTH (DATA_WIDTH),
        .SEQ_INIT   (SEQ_INIT)
    ) u_seq_check (
        .CLK      (CLK),
        .nRST     (nRST),
        .take     (take_c),
        .data     (head_q),
        .ERR_CNT  (ERR_CNT),
        .ERR_FLAG (ERR_FLAG)
    );
`else
    logic [DATA_WIDTH-1:0] seq_init_unused;
    assign seq_init_unused = SEQ_INIT;
    assign ERR_CNT  = '0;
    assign ERR_FLAG = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_pop_stream.sv
// Directed bench for fifo_pop_stream with a behavioural FWFT FIFO and an output capture log.
module tb_fifo_pop_stream;

    localparam int unsigned DW = 32;

    logic          CLK;
    logic          nRST;
    logic          F_EMPTY;
    logic [DW-1:0] F_DATA;
    logic          F_nEN;
    logic          O_VALID;
    logic          O_READY;
    logic [DW-1:0] O_DATA;
    logic [31:0]   XFER_CNT;
    logic [15:0]   ERR_CNT;
    logic          ERR_FLAG;

    fifo_pop_stream #(.DATA_WIDTH(DW), .SEQ_INIT('0)) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .F_EMPTY  (F_EMPTY),
        .F_DATA   (F_DATA),
        .F_nEN    (F_nEN),
        .O_VALID  (O_VALID),
        .O_READY  (O_READY),
        .O_DATA   (O_DATA),
        .XFER_CNT (XFER_CNT),
        .ERR_CNT  (ERR_CNT),
        .ERR_FLAG (ERR_FLAG)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural FWFT FIFO: gate_empty injects bubbles without losing contents.
    logic [DW-1:0] fifo_mem [0:63];
    int            wr_ptr = 0;
    int            rd_ptr = 0;
    int            pop_cnt = 0;
    logic          gate_empty;

    assign F_EMPTY = gate_empty || (rd_ptr == wr_ptr);
    assign F_DATA  = fifo_mem[rd_ptr[5:0]];

    always @(posedge CLK) begin
        if (!F_nEN && !F_EMPTY) begin
            rd_ptr  <= rd_ptr + 1;
            pop_cnt <= pop_cnt + 1;
        end
    end

    // Log of every accepted output word.
    logic [DW-1:0] out_mem [0:255];
    int            out_cnt = 0;

    always @(posedge CLK) begin
        if (nRST && O_VALID && O_READY) begin
            out_mem[out_cnt[7:0]] <= O_DATA;
            out_cnt               <= out_cnt + 1;
        end
    end

    int pass_cnt = 0;
    int chk_cnt  = 0;

    task automatic fifo_write(input logic [DW-1:0] v);
        fifo_mem[wr_ptr[5:0]] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        gate_empty = 1'b1;
        O_READY    = 1'b0;
        nRST       = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        int p0;
        gate_empty = 1'b0;
        O_READY    = 1'b0;
        nRST       = 1'b0;
        fifo_write(32'hA5A5_0001);
        p0 = pop_cnt;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            #1;
            chk_cnt++;
            if (F_nEN !== 1'b1) $display("FAIL reset_fnen[%0d] got %b want 1", i, F_nEN);
            else pass_cnt++;
        end
        chk_cnt++;
        if (pop_cnt !== p0) $display("FAIL reset_no_pop got %0d want %0d", pop_cnt, p0);
        else pass_cnt++;
        chk_cnt++;
        if (O_VALID !== 1'b0) $display("FAIL reset_valid got %b want 0", O_VALID);
        else pass_cnt++;
        chk_cnt++;
        if (XFER_CNT !== 32'd0) $display("FAIL reset_xfer got %0d want 0", XFER_CNT);
        else pass_cnt++;
        chk_cnt++;
        if (ERR_CNT !== 16'd0 || ERR_FLAG !== 1'b0)
            $display("FAIL reset_err got %0d/%b want 0/0", ERR_CNT, ERR_FLAG);
        else pass_cnt++;
        // Release: the word that waited through reset must come out first.
        nRST    = 1'b1;
        O_READY = 1'b1;
        @(negedge CLK);
        #1;
        chk_cnt++;
        if (O_VALID !== 1'b1 || O_DATA !== 32'hA5A5_0001)
            $display("FAIL reset_first_word got %b/%h want 1/a5a50001", O_VALID, O_DATA);
        else pass_cnt++;
        @(negedge CLK);
    endtask

    task automatic test_streaming();
        int base;
        do_reset();
        for (int i = 0; i < 10; i++) fifo_write(DW'(i));
        base = out_cnt;
        @(negedge CLK);
        O_READY    = 1'b1;
        gate_empty = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k > 0) @(negedge CLK);
            #1;
            chk_cnt++;
            if (F_nEN !== ((k < 10) ? 1'b0 : 1'b1))
                $display("FAIL stream_fnen[%0d] got %b", k, F_nEN);
            else pass_cnt++;
            if (k >= 1 && k <= 10) begin
                chk_cnt++;
                if (O_VALID !== 1'b1 || O_DATA !== DW'(k - 1))
                    $display("FAIL stream_data[%0d] got %b/%0d want 1/%0d", k, O_VALID, O_DATA, k - 1);
                else pass_cnt++;
            end
        end
        chk_cnt++;
        if (O_VALID !== 1'b0) $display("FAIL stream_drained got %b want 0", O_VALID);
        else pass_cnt++;
        chk_cnt++;
        if (XFER_CNT !== 32'd10 || (out_cnt - base) != 10)
            $display("FAIL stream_xfer got %0d want 10", XFER_CNT);
        else pass_cnt++;
        chk_cnt++;
        if (ERR_CNT !== 16'd0) $display("FAIL stream_err got %0d want 0", ERR_CNT);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        int base;
        int p0;
        int guard;
        do_reset();
        for (int i = 0; i < 6; i++) fifo_write(DW'(i));
        base = out_cnt;
        p0   = pop_cnt;
        @(negedge CLK);
        gate_empty = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            #1;
            if (k >= 1) begin
                chk_cnt++;
                if (F_nEN !== 1'b1 || O_VALID !== 1'b1 || O_DATA !== DW'(0))
                    $display("FAIL bp_hold[%0d] got fnen=%b v=%b d=%0d want 1/1/0", k, F_nEN, O_VALID, O_DATA);
                else pass_cnt++;
            end
        end
        chk_cnt++;
        if (pop_cnt - p0 != 2) $display("FAIL bp_pops got %0d want 2", pop_cnt - p0);
        else pass_cnt++;
        // In FULL the first new pop waits until the cycle after the take.
        O_READY = 1'b1;
        #1;
        chk_cnt++;
        if (F_nEN !== 1'b1) $display("FAIL bp_release_fnen0 got %b want 1", F_nEN);
        else pass_cnt++;
        @(negedge CLK);
        #1;
        chk_cnt++;
        if (F_nEN !== 1'b0) $display("FAIL bp_release_fnen1 got %b want 0", F_nEN);
        else pass_cnt++;
        guard = 0;
        while ((out_cnt - base) < 6 && guard < 50) begin
            @(negedge CLK);
            guard++;
        end
        repeat (3) @(negedge CLK);
        chk_cnt++;
        if ((out_cnt - base) != 6) $display("FAIL bp_count got %0d want 6", out_cnt - base);
        else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            chk_cnt++;
            if (out_mem[(base + i) % 256] !== DW'(i))
                $display("FAIL bp_order[%0d] got %0d want %0d", i, out_mem[(base + i) % 256], i);
            else pass_cnt++;
        end
        chk_cnt++;
        if (XFER_CNT !== 32'd6) $display("FAIL bp_xfer got %0d want 6", XFER_CNT);
        else pass_cnt++;
    endtask

    task automatic test_bubbles();
        int base;
        int cyc;
        do_reset();
        for (int i = 0; i < 20; i++) fifo_write(DW'(100 + i));
        base = out_cnt;
        cyc  = 0;
        while ((out_cnt - base) < 20 && cyc < 300) begin
            @(negedge CLK);
            gate_empty = cyc[0];
            O_READY    = !cyc[1];
            cyc++;
        end
        O_READY = 1'b1;
        repeat (4) @(negedge CLK);
        chk_cnt++;
        if ((out_cnt - base) != 20) $display("FAIL bubble_count got %0d want 20", out_cnt - base);
        else pass_cnt++;
        for (int i = 0; i < 20; i++) begin
            chk_cnt++;
            if (out_mem[(base + i) % 256] !== DW'(100 + i))
                $display("FAIL bubble_order[%0d] got %0d want %0d", i, out_mem[(base + i) % 256], 100 + i);
            else pass_cnt++;
        end
        chk_cnt++;
        if (XFER_CNT !== 32'd20) $display("FAIL bubble_xfer got %0d want 20", XFER_CNT);
        else pass_cnt++;
    endtask

    task automatic test_seq_check();
        logic [DW-1:0] vec [0:6];
        int            base;
        int            guard;
        logic [15:0]   exp_cnt;
        logic          exp_flag;
        vec[0] = 32'd0; vec[1] = 32'd1; vec[2] = 32'd2; vec[3] = 32'd5;
        vec[4] = 32'd4; vec[5] = 32'd5; vec[6] = 32'd6;
`ifdef FIFO_POP_SEQ_CHECK_EN
        exp_cnt  = 16'd1;
        exp_flag = 1'b1;
`else
        exp_cnt  = 16'd0;
        exp_flag = 1'b0;
`endif
        do_reset();
        for (int i = 0; i < 7; i++) fifo_write(vec[i]);
        base = out_cnt;
        @(negedge CLK);
        O_READY    = 1'b1;
        gate_empty = 1'b0;
        guard = 0;
        while ((out_cnt - base) < 7 && guard < 50) begin
            @(negedge CLK);
            guard++;
        end
        chk_cnt++;
        if ((out_cnt - base) != 7) $display("FAIL seq_count got %0d want 7", out_cnt - base);
        else pass_cnt++;
        chk_cnt++;
        if (ERR_CNT !== exp_cnt) $display("FAIL seq_err_cnt got %0d want %0d", ERR_CNT, exp_cnt);
        else pass_cnt++;
        chk_cnt++;
        if (ERR_FLAG !== exp_flag) $display("FAIL seq_err_flag got %b want %b", ERR_FLAG, exp_flag);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 7; i++) fifo_write(DW'(200 + i));
        @(negedge CLK);
        gate_empty = 1'b0;
        O_READY    = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        O_READY = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        #1;
        chk_cnt++;
        if (F_nEN !== 1'b1 || O_DATA !== DW'(201) || XFER_CNT !== 32'd1)
            $display("FAIL mid_full got fnen=%b d=%0d x=%0d want 1/201/1", F_nEN, O_DATA, XFER_CNT);
        else pass_cnt++;
        nRST = 1'b0;
        #1;
        chk_cnt++;
        if (F_nEN !== 1'b1) $display("FAIL mid_rst_fnen got %b want 1", F_nEN);
        else pass_cnt++;
        @(negedge CLK);
        #1;
        chk_cnt++;
        if (O_VALID !== 1'b0 || XFER_CNT !== 32'd0 || F_nEN !== 1'b1)
            $display("FAIL mid_rst_state got v=%b x=%0d fnen=%b want 0/0/1", O_VALID, XFER_CNT, F_nEN);
        else pass_cnt++;
        nRST = 1'b1;
        #1;
        chk_cnt++;
        if (F_nEN !== 1'b0) $display("FAIL mid_release_fnen got %b want 0", F_nEN);
        else pass_cnt++;
        @(negedge CLK);
        #1;
        chk_cnt++;
        if (O_VALID !== 1'b1 || O_DATA !== DW'(203))
            $display("FAIL mid_next_word got %b/%0d want 1/203", O_VALID, O_DATA);
        else pass_cnt++;
    endtask

    initial begin
        nRST       = 1'b0;
        gate_empty = 1'b1;
        O_READY    = 1'b0;
        for (int i = 0; i < 64; i++) fifo_mem[i] = '0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_bubbles();
        test_seq_check();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
